// File: rtl/sdr_arb_pkg.sv
// rtl/sdr_arb_pkg.sv - shared types and widths for the SDRAM client arbiter
package sdr_arb_pkg;
  localparam int ADDR_W  = 32;
  localparam int NELEM_W = 30;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef enum logic {OP_RD, OP_WR} op_e;
endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, search starts after last_i
module rr_pick #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic         valid_o,
  output logic [W-1:0] idx_o
);
  always_comb begin
    int j;
    valid_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    // Walk from the farthest candidate to the nearest so the nearest wins.
    for (int k = N; k >= 1; k--) begin
      j = (int'(last_i) + k) % N;
      if (req_i[j]) begin
        valid_o = 1'b1;
        idx_o   = W'(j);
      end
    end
  end
endmodule

// File: rtl/sdr_arbiter.sv
// rtl/sdr_arbiter.sv - round-robin sharing of one avalon_sdr transfer engine
module sdr_arbiter import sdr_arb_pkg::*; #(
  parameter int NREQ       = 4,
  parameter int MAX_NREAD  = 64,
  parameter int MAX_NWRITE = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [32*NREQ-1:0]             req_baseaddr,
  input  logic [30*NREQ-1:0]             req_nelems,
  input  logic [32*MAX_NWRITE*NREQ-1:0]  req_writedata,
  input  logic [NREQ-1:0]                req_readstart,
  input  logic [NREQ-1:0]                req_writestart,
  output logic [NREQ-1:0]                req_readend,
  output logic [NREQ-1:0]                req_writeend,
  output logic [32*MAX_NREAD-1:0]        req_readdata,
  output logic                           busy,
  output logic [$clog2(NREQ)-1:0]        grant_id,
  output logic [31:0]                    sdr_baseaddr,
  output logic [29:0]                    sdr_nelems,
  output logic [32*MAX_NWRITE-1:0]       sdr_writedata,
  output logic                           sdr_readstart,
  output logic                           sdr_writestart,
  input  logic [32*MAX_NREAD-1:0]        sdr_readdata,
  input  logic                           sdr_readend,
  input  logic                           sdr_writeend
);
  localparam int GW   = $clog2(NREQ);
  localparam int WD_W = 32 * MAX_NWRITE;
  localparam logic [NELEM_W-1:0] RD_CAP = NELEM_W'(MAX_NREAD / 2);
  localparam logic [NELEM_W-1:0] WR_CAP = NELEM_W'(MAX_NWRITE / 2);

  state_e             state_q;
  op_e                op_q;
  logic [GW-1:0]      grant_q, ptr_q;
  logic [ADDR_W-1:0]  base_q;
  logic [NELEM_W-1:0] nelems_q;
  logic               rdstart_q, wrstart_q;
  logic [NREQ-1:0]    rdend_q, wrend_q;
  logic [NREQ-1:0]    pend_rd_q, pend_wr_q, pend_rd_d, pend_wr_d;

  logic [ADDR_W-1:0]  base_a [NREQ];
  logic [NELEM_W-1:0] nel_a  [NREQ];
  logic [WD_W-1:0]    wd_a   [NREQ];

  logic               pick_valid, pick_wr;
  logic [GW-1:0]      pick_idx;
  logic [NELEM_W-1:0] pick_raw, pick_cap, pick_nel;
  logic [NREQ-1:0]    grant_oh, pick_oh;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      base_a[i] = req_baseaddr[ADDR_W*i +: ADDR_W];
      nel_a[i]  = req_nelems[NELEM_W*i +: NELEM_W];
      wd_a[i]   = req_writedata[WD_W*i +: WD_W];
    end
  end

  rr_pick #(.N(NREQ), .W(GW)) u_pick (
    .req_i   (pend_rd_q | pend_wr_q),
    .last_i  (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign grant_oh = NREQ'(1) << grant_q;
  assign pick_oh  = NREQ'(1) << pick_idx;
  assign pick_wr  = pend_wr_q[pick_idx];
  assign pick_raw = nel_a[pick_idx];
  assign pick_cap = pick_wr ? WR_CAP : RD_CAP;
  assign pick_nel = (pick_raw > pick_cap) ? pick_cap : pick_raw;

  // A new start wins over the clear issued by the job's own completion.
  always_comb begin
    pend_rd_d = pend_rd_q | req_readstart;
    pend_wr_d = pend_wr_q | req_writestart;
    if (state_q == DONE) begin
      if (op_q == OP_RD) pend_rd_d = (pend_rd_q & ~grant_oh) | req_readstart;
      else               pend_wr_d = (pend_wr_q & ~grant_oh) | req_writestart;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      op_q      <= OP_RD;
      grant_q   <= '0;
      ptr_q     <= GW'(NREQ - 1);
      base_q    <= '0;
      nelems_q  <= '0;
      rdstart_q <= 1'b0;
      wrstart_q <= 1'b0;
      rdend_q   <= '0;
      wrend_q   <= '0;
      pend_rd_q <= '0;
      pend_wr_q <= '0;
    end else begin
      pend_rd_q <= pend_rd_d;
      pend_wr_q <= pend_wr_d;
      rdstart_q <= 1'b0;
      wrstart_q <= 1'b0;
      rdend_q   <= '0;
      wrend_q   <= '0;
      case (state_q)
        IDLE: if (pick_valid) begin
          grant_q  <= pick_idx;
          ptr_q    <= pick_idx;
          op_q     <= pick_wr ? OP_WR : OP_RD;
          base_q   <= base_a[pick_idx];
          nelems_q <= pick_nel;
          // Zero-length jobs skip the engine, whose max_offset would underflow.
          if (pick_nel == '0) begin
            state_q <= DONE;
            if (pick_wr) wrend_q <= pick_oh;
            else         rdend_q <= pick_oh;
          end else begin
            state_q   <= ISSUE;
            rdstart_q <= ~pick_wr;
            wrstart_q <= pick_wr;
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (op_q == OP_RD && sdr_readend) begin
            state_q <= DONE;
            rdend_q <= grant_oh;
          end else if (op_q == OP_WR && sdr_writeend) begin
            state_q <= DONE;
            wrend_q <= grant_oh;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy           = (state_q != IDLE);
  assign grant_id       = grant_q;
  assign sdr_baseaddr   = base_q;
  assign sdr_nelems     = nelems_q;
  assign sdr_readstart  = rdstart_q;
  assign sdr_writestart = wrstart_q;
  assign req_readend    = rdend_q;
  assign req_writeend   = wrend_q;
  assign sdr_writedata  = wd_a[grant_q];
  assign req_readdata   = sdr_readdata;
endmodule

// File: tb/tb_sdr_arbiter.sv
// tb/tb_sdr_arbiter.sv - scoreboard bench for the SDRAM client arbiter
module tb_sdr_arbiter;
  localparam int NREQ = 4;
  localparam int MAX_NREAD = 64;
  localparam int MAX_NWRITE = 64;

  logic                          clk, reset;
  logic [32*NREQ-1:0]            req_baseaddr;
  logic [30*NREQ-1:0]            req_nelems;
  logic [32*MAX_NWRITE*NREQ-1:0] req_writedata;
  logic [NREQ-1:0]               req_readstart, req_writestart, req_readend, req_writeend;
  logic [32*MAX_NREAD-1:0]       req_readdata, sdr_readdata;
  logic                          busy, sdr_readstart, sdr_writestart, sdr_readend, sdr_writeend;
  logic [1:0]                    grant_id;
  logic [31:0]                   sdr_baseaddr;
  logic [29:0]                   sdr_nelems;
  logic [32*MAX_NWRITE-1:0]      sdr_writedata;

  sdr_arbiter #(.NREQ(NREQ), .MAX_NREAD(MAX_NREAD), .MAX_NWRITE(MAX_NWRITE)) dut (
    .clk(clk), .reset(reset),
    .req_baseaddr(req_baseaddr), .req_nelems(req_nelems), .req_writedata(req_writedata),
    .req_readstart(req_readstart), .req_writestart(req_writestart),
    .req_readend(req_readend), .req_writeend(req_writeend), .req_readdata(req_readdata),
    .busy(busy), .grant_id(grant_id),
    .sdr_baseaddr(sdr_baseaddr), .sdr_nelems(sdr_nelems), .sdr_writedata(sdr_writedata),
    .sdr_readstart(sdr_readstart), .sdr_writestart(sdr_writestart),
    .sdr_readdata(sdr_readdata), .sdr_readend(sdr_readend), .sdr_writeend(sdr_writeend)
  );

  // kind: 0 engine read start, 1 engine write start, 2 client readend, 3 client writeend
  typedef struct {
    int          kind;
    int          gid;
    int          mask;
    logic [31:0] addr;
    logic [29:0] nel;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  t;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int kind, int gid, int mask, logic [31:0] addr, logic [29:0] nel,
                      logic [31:0] data, int c);
    ev_t e;
    e.kind = kind; e.gid = gid; e.mask = mask; e.addr = addr;
    e.nel = nel; e.data = data; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic observe(int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk("event_kind", 64'(kind), 64'(e.kind));
    chk("event_cycle", 64'(cyc), 64'(e.cyc));
    chk("grant_id", 64'(grant_id), 64'(e.gid));
    if (kind < 2) begin
      chk("sdr_baseaddr", 64'(sdr_baseaddr), 64'(e.addr));
      chk("sdr_nelems", 64'(sdr_nelems), 64'(e.nel));
      if (kind == 1) chk("sdr_writedata", 64'(sdr_writedata[31:0]), 64'(e.data));
    end else if (kind == 2) begin
      chk("req_readend", 64'(req_readend), 64'(e.mask));
      chk("req_readdata", 64'(req_readdata[31:0]), 64'(e.data));
    end else begin
      chk("req_writeend", 64'(req_writeend), 64'(e.mask));
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (sdr_readstart)   observe(0);
      if (sdr_writestart)  observe(1);
      if (|req_readend)    observe(2);
      if (|req_writeend)   observe(3);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) tick();
  endtask

  task automatic set_client(int i, logic [31:0] a, logic [29:0] n, logic [31:0] d);
    req_baseaddr[32*i +: 32] = a;
    req_nelems[30*i +: 30] = n;
    req_writedata[32*MAX_NWRITE*i +: 32] = d;
  endtask

  task automatic eng_end(int c, bit is_wr, logic [31:0] d);
    wait_cyc(c);
    if (is_wr) sdr_writeend = 1'b1;
    else begin
      sdr_readdata[31:0] = d;
      sdr_readend = 1'b1;
    end
    tick();
    sdr_writeend = 1'b0;
    sdr_readend = 1'b0;
  endtask

  task automatic check_quiet(string tag);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_grant_id"}, 64'(grant_id), 0);
    chk({tag, "_starts"}, 64'({sdr_readstart, sdr_writestart}), 0);
    chk({tag, "_ends"}, 64'({req_readend, req_writeend}), 0);
    chk({tag, "_baseaddr"}, 64'(sdr_baseaddr), 0);
    chk({tag, "_nelems"}, 64'(sdr_nelems), 0);
  endtask

  initial begin
    reset = 1'b1;
    req_baseaddr = '0; req_nelems = '0; req_writedata = '0;
    req_readstart = '0; req_writestart = '0;
    sdr_readdata = '0; sdr_readend = 1'b0; sdr_writeend = 1'b0;
    tick(); tick();
    check_quiet("reset");
    reset = 1'b0;
    tick(); tick();

    // Two simultaneous writes from pointer NREQ-1, a duplicate start, a stray read end.
    set_client(1, 32'h2000, 30'd8, 32'h1111_0000);
    set_client(3, 32'h3000, 30'd40, 32'h3333_0000);
    t = cyc;
    push(1, 1, 0, 32'h2000, 30'd8, 32'h1111_0000, t + 2);
    push(3, 1, 2, 0, 0, 0, t + 5);
    push(1, 3, 0, 32'h3000, 30'd32, 32'h3333_0000, t + 7);
    push(3, 3, 8, 0, 0, 0, t + 10);
    req_writestart = 4'b1010; tick(); req_writestart = '0;
    wait_cyc(t + 3); req_writestart = 4'b0010; tick(); req_writestart = '0;
    eng_end(t + 4, 1'b1, 0);
    eng_end(t + 8, 1'b0, 32'hDEAD_0000);
    eng_end(t + 9, 1'b1, 0);
    wait_cyc(t + 12);

    // Plain read from client 0.
    set_client(0, 32'h1000, 30'd4, 0);
    t = cyc;
    push(0, 0, 0, 32'h1000, 30'd4, 0, t + 2);
    push(2, 0, 1, 0, 0, 32'hCAFE_0001, t + 5);
    req_readstart = 4'b0001; tick(); req_readstart = '0;
    eng_end(t + 4, 1'b0, 32'hCAFE_0001);
    wait_cyc(t + 7);

    // Client 2 requests both: write first, then read.
    set_client(2, 32'h4000, 30'd2, 32'h2222_0000);
    t = cyc;
    push(1, 2, 0, 32'h4000, 30'd2, 32'h2222_0000, t + 2);
    push(3, 2, 4, 0, 0, 0, t + 5);
    push(0, 2, 0, 32'h4000, 30'd2, 0, t + 7);
    push(2, 2, 4, 0, 0, 32'hBEEF_0002, t + 10);
    req_readstart = 4'b0100; req_writestart = 4'b0100; tick();
    req_readstart = '0; req_writestart = '0;
    eng_end(t + 4, 1'b1, 0);
    eng_end(t + 9, 1'b0, 32'hBEEF_0002);
    wait_cyc(t + 12);

    // Zero-length read never reaches the engine.
    set_client(0, 32'h6000, 30'd0, 0);
    t = cyc;
    push(2, 0, 1, 0, 0, 32'hBEEF_0002, t + 2);
    req_readstart = 4'b0001; tick(); req_readstart = '0;
    wait_cyc(t + 5);

    // Oversized read clamps to MAX_NREAD/2.
    set_client(1, 32'h7000, 30'd100, 0);
    t = cyc;
    push(0, 1, 0, 32'h7000, 30'd32, 0, t + 2);
    push(2, 1, 2, 0, 0, 32'h0000_0064, t + 5);
    req_readstart = 4'b0010; tick(); req_readstart = '0;
    eng_end(t + 4, 1'b0, 32'h0000_0064);
    wait_cyc(t + 7);

    // Reset while waiting on the engine drops the job silently.
    set_client(1, 32'h8000, 30'd3, 32'h8888_0000);
    t = cyc;
    push(1, 1, 0, 32'h8000, 30'd3, 32'h8888_0000, t + 2);
    req_writestart = 4'b0010; tick(); req_writestart = '0;
    wait_cyc(t + 4);
    reset = 1'b1;
    #1;
    check_quiet("midreset");
    tick(); tick();
    reset = 1'b0;
    eng_end(t + 7, 1'b1, 0);
    wait_cyc(t + 10);

    set_client(3, 32'h5000, 30'd5, 0);
    t = cyc;
    push(0, 3, 0, 32'h5000, 30'd5, 0, t + 2);
    push(2, 3, 8, 0, 0, 32'h0000_0055, t + 5);
    req_readstart = 4'b1000; tick(); req_readstart = '0;
    eng_end(t + 4, 1'b0, 32'h0000_0055);
    wait_cyc(t + 8);

    chk("events_outstanding", 64'(exp_q.size()), 0);
    chk("final_busy", 64'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
